fix_to_half: RTL and testbench

Converts a signed 16-bit fixed-point sample (two's complement, FRAC_BITS fractional bits) into an IEEE-754 half-precision value, rounded to nearest-even. It sits directly upstream of the half-precision float divider and feeds its `input_a` / `input_b` operand ports. It uses the same strobe/acknowledge handshake as the divider, so its output connects port-to-port with no glue logic.

---
 rtl/fix_to_half_if.sv | 25 ++
 rtl/fix_to_half.sv | 109 ++++++++++
 tb/tb_fix_to_half.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fix_to_half_if.sv
// fix_to_half_if: strobe/acknowledge operand and result channels of the fixed-point to half converter
// Signals:
//   input_a      16  signed fixed-point operand (master -> converter)
//   input_a_stb   1  operand valid
//   input_a_ack   1  converter ready for an operand
//   output_z     16  half-precision result {sign, exp[4:0], mant[9:0]}
//   output_z_stb  1  result valid
//   output_z_ack  1  downstream accepts the result
// Modports: slave is the converter's view, master is the upstream/downstream environment.
interface fix_to_half_if;
    logic [15:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [15:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;
    modport slave (
        input  input_a, input_a_stb, output_z_ack,
        output input_a_ack, output_z, output_z_stb
    );
    modport master (
        output input_a, input_a_stb, output_z_ack,
        input  input_a_ack, output_z, output_z_stb
    );
endinterface

// File: rtl/fix_to_half.sv
// fix_to_half: signed 16-bit fixed-point to IEEE-754 half converter, round to nearest-even
// Ports:
//   clk  rising-edge system clock
//   rst  synchronous active-high reset, aborts any conversion in flight
//   io   fix_to_half_if.slave: input_a/_stb/_ack operand channel, output_z/_stb/_ack result channel
// Parameter FRAC_BITS (0..14): fractional bits of input_a; within this range every
// non-zero result is a normal half, so no overflow or subnormal handling exists.
module fix_to_half #(
    parameter int FRAC_BITS = 8
) (
    input logic        clk,
    input logic        rst,
    fix_to_half_if.slave io
);
    typedef enum logic [2:0] {GET_A, UNPACK, NORMALISE, ROUND, PACK, PUT_Z} state_t;
    state_t state, state_n;
    logic [15:0] a, a_n;
    logic [15:0] mag, mag_n;
    logic [15:0] z, z_n;
    logic        sign, sign_n;
    logic signed [6:0] exp, exp_n;
    logic [9:0]  m, m_n;
    logic        ack, ack_n;
    logic        stb, stb_n;
    logic        rnd_up;
    logic [10:0] m_rnd;
    logic signed [6:0] exp_b;
    // round up on guard set when sticky is set or on an exact tie with odd lsb
    assign rnd_up = mag[4] & ((|mag[3:0]) | mag[5]);
    // bit 10 is the carry out of the mantissa; the low bits are then already zero
    assign m_rnd  = {1'b0, mag[14:5]} + {10'd0, rnd_up};
    assign exp_b  = exp + 7'sd15;
    assign io.input_a_ack  = ack;
    assign io.output_z     = z;
    assign io.output_z_stb = stb;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= GET_A;
            a     <= '0;
            mag   <= '0;
            z     <= '0;
            sign  <= 1'b0;
            exp   <= '0;
            m     <= '0;
            ack   <= 1'b0;
            stb   <= 1'b0;
        end else begin
            state <= state_n;
            a     <= a_n;
            mag   <= mag_n;
            z     <= z_n;
            sign  <= sign_n;
            exp   <= exp_n;
            m     <= m_n;
            ack   <= ack_n;
            stb   <= stb_n;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            GET_A:     state_n = (ack && io.input_a_stb) ? UNPACK : GET_A;
            UNPACK:    state_n = (a == 16'h0000) ? PUT_Z : NORMALISE;
            NORMALISE: state_n = mag[15] ? ROUND : NORMALISE;
            ROUND:     state_n = PACK;
            PACK:      state_n = PUT_Z;
            PUT_Z:     state_n = (stb && io.output_z_ack) ? GET_A : PUT_Z;
            default:   state_n = GET_A;
        endcase
    end
    always_comb begin
        a_n    = a;
        mag_n  = mag;
        z_n    = z;
        sign_n = sign;
        exp_n  = exp;
        m_n    = m;
        ack_n  = 1'b0;
        stb_n  = stb;
        case (state)
            GET_A: begin
                ack_n = ~(ack && io.input_a_stb);
                a_n   = (ack && io.input_a_stb) ? io.input_a : a;
            end
            UNPACK: begin
                // 16'h8000 negates to itself, which is the correct unsigned magnitude
                sign_n = a[15];
                mag_n  = a[15] ? (~a + 16'd1) : a;
                exp_n  = 7'(15 - FRAC_BITS);
                z_n    = (a == 16'h0000) ? 16'h0000 : z;
                stb_n  = (a == 16'h0000);
            end
            NORMALISE: begin
                mag_n = mag[15] ? mag : {mag[14:0], 1'b0};
                exp_n = mag[15] ? exp : exp - 7'sd1;
            end
            ROUND: begin
                m_n   = m_rnd[9:0];
                exp_n = m_rnd[10] ? exp + 7'sd1 : exp;
            end
            PACK: begin
                z_n   = {sign, exp_b[4:0], m};
                stb_n = 1'b1;
            end
            PUT_Z: stb_n = ~(stb && io.output_z_ack);
            default: stb_n = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_fix_to_half.sv
// tb_fix_to_half: directed scoreboard bench for fix_to_half (FRAC_BITS = 8)
module tb_fix_to_half;
    localparam int FRAC = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [15:0] sbq[$];
    always #5 clk = ~clk;
    fix_to_half_if io();
    fix_to_half #(.FRAC_BITS(FRAC)) dut (.clk(clk), .rst(rst), .io(io));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // independent reference: locate msb, keep 11 significant bits, round half to even
    function automatic void model(input logic [15:0] a, output logic [15:0] z, output int lat);
        int mg, p, e, sh, q, rem, half;
        logic s;
        p = 0;
        if (a == 16'h0000) begin
            z = 16'h0000;
            lat = 1;
            return;
        end
        s = a[15];
        mg = s ? 65536 - int'(a) : int'(a);
        for (int i = 0; i < 17; i++) if ((mg >> i) != 0) p = i;
        e = p - FRAC;
        if (p > 10) begin
            sh = p - 10;
            q = mg >> sh;
            rem = mg % (1 << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && q % 2 == 1)) q++;
            if (q == 2048) begin
                q = 1024;
                e++;
            end
        end else begin
            q = mg << (10 - p);
        end
        z = {s, 5'(e + 15), 10'(q % 1024)};
        lat = (15 - p) + 4;
    endfunction

    // caller is 1 time unit after an edge; returns edges waited before the transfer edge
    task automatic send(input logic [15:0] a, input logic [15:0] ez, output int n);
        n = 0;
        io.input_a = a;
        io.input_a_stb = 1'b1;
        while (!io.input_a_ack && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ack_timeout", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        io.input_a_stb = 1'b0;
        sbq.push_back(ez);
    endtask

    // hold > 0 expects output_z_ack low on entry, checks stability, then releases it
    task automatic recv(input string tag, input int elat, input int hold);
        int n;
        logic [15:0] e, zq;
        n = 0;
        while (!io.output_z_stb && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("%s_latency", tag), 32'(n), 32'(elat));
        e = (sbq.size() > 0) ? sbq.pop_front() : 16'hxxxx;
        check($sformatf("%s_z", tag), {16'd0, io.output_z}, {16'd0, e});
        zq = io.output_z;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s_hold_z", tag), {16'd0, io.output_z}, {16'd0, zq});
            check($sformatf("%s_hold_stb", tag), 32'(io.output_z_stb), 32'd1);
            check($sformatf("%s_hold_ack", tag), 32'(io.input_a_ack), 32'd0);
        end
        io.output_z_ack = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s_stb_drop", tag), 32'(io.output_z_stb), 32'd0);
        check($sformatf("%s_ack_low", tag), 32'(io.input_a_ack), 32'd0);
        @(posedge clk); #1;
        check($sformatf("%s_ack_back", tag), 32'(io.input_a_ack), 32'd1);
    endtask

    initial begin
        int n, lat;
        logic [15:0] a, ez;
        io.input_a = 16'h0100;
        io.input_a_stb = 1'b1;
        io.output_z_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 32'(io.input_a_ack), 32'd0);
        check("reset_stb", 32'(io.output_z_stb), 32'd0);
        check("reset_z", {16'd0, io.output_z}, 32'd0);
        rst = 1'b0;
        send(16'h0100, 16'h3C00, n);
        check("first_transfer_edge", 32'(n), 32'd1);
        recv("one", 11, 0);
        send(16'hFF00, 16'hBC00, n);
        recv("minus_one", 11, 0);
        send(16'h068E, 16'h468E, n);
        recv("op_a", 9, 0);
        send(16'h00A8, 16'h3940, n);
        recv("op_b", 12, 0);
        send(16'h4008, 16'h5400, n);
        recv("tie_even", 5, 0);
        send(16'h4018, 16'h5402, n);
        recv("tie_odd", 5, 0);
        send(16'h7FFF, 16'h5800, n);
        recv("carry", 5, 0);
        send(16'h8000, 16'hD800, n);
        recv("most_neg", 4, 0);
        send(16'h0000, 16'h0000, n);
        recv("zero", 1, 0);
        send(16'h0001, 16'h1C00, n);
        recv("lsb", 19, 0);
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom);
            model(a, ez, lat);
            send(a, ez, n);
            recv($sformatf("rand_%0h", a), lat, 0);
        end
        io.output_z_ack = 1'b0;
        send(16'h0100, 16'h3C00, n);
        recv("backpressure", 11, 20);
        send(16'h0001, 16'h1C00, n);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sbq.pop_back());
        check("abort_stb", 32'(io.output_z_stb), 32'd0);
        check("abort_z", {16'd0, io.output_z}, 32'd0);
        check("abort_ack", 32'(io.input_a_ack), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_stale", 32'(io.output_z_stb), 32'd0);
        end
        send(16'h0100, 16'h3C00, n);
        recv("after_abort", 11, 0);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
